bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter sharing the single bus master port between NUM_REQ requesters (DMA, CPU bridge, ...).

---
 rtl/bus_arbiter_rr.sv | 165 ++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter that hands the single shared bus master port to one of
//   NUM_REQ requesters. A winner gets a one-cycle grant pulse, after which the
//   arbiter follows its transaction through begin/end strobes and releases the
//   bus on end/error. A watchdog abandons owners that never start and aborts
//   transactions that never finish.
//
// Ports
//   clock               in   1        system clock, rising edge
//   reset               in   1        synchronous, active-high
//   request             in   NUM_REQ  level request per master
//   granted             out  NUM_REQ  one-hot grant pulse, one cycle wide
//   begin_transactionIN in   1        begin strobe from the current owner
//   end_transactionIN   in   1        end strobe (owner or slave)
//   errorIN             in   1        bus error from slave
//   end_transactionOUT  out  1        forced end pulse on watchdog abort
//   errorOUT            out  1        error pulse on watchdog abort
//   ownerValid          out  1        bus currently owned
//   currentOwner        out  OWNER_W  index of the granted master (sticky)
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned START_TIMEOUT = 8,
    parameter int unsigned BUSY_TIMEOUT  = 255,
    localparam int unsigned OWNER_W      = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    output logic [NUM_REQ-1:0] granted,
    input  logic               begin_transactionIN,
    input  logic               end_transactionIN,
    input  logic               errorIN,
    output logic               end_transactionOUT,
    output logic               errorOUT,
    output logic               ownerValid,
    output logic [OWNER_W-1:0] currentOwner
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BEGIN,
        BUSY,
        RELEASE
    } arbStateT;

    arbStateT             state, stateNext;
    logic [7:0]           counter, counterNext, counterInc;
    logic [OWNER_W-1:0]   pointer, pointerNext;
    logic [OWNER_W-1:0]   ownerNext;
    logic [NUM_REQ-1:0]   grantedNext;
    logic                 ownerValidNext;
    logic                 endOutNext;
    logic                 errOutNext;

    // Round-robin pick
    logic [2*NUM_REQ-1:0] reqTwice;
    logic [NUM_REQ-1:0]   reqRot;
    logic [OWNER_W-1:0]   offset;
    logic [OWNER_W:0]     ownerSum;
    logic [OWNER_W-1:0]   ownerPick;

    // Rotating the doubled request vector by the pointer turns the circular
    // scan into a plain lowest-set-bit search; the winner is pointer+offset
    // folded back into 0..NUM_REQ-1.
    always_comb begin
        reqTwice = {request, request};
        reqRot   = reqTwice[pointer +: NUM_REQ];
        offset   = '0;
        for (int unsigned j = NUM_REQ; j > 0; j--) begin
            if (reqRot[OWNER_W'(j - 1)]) begin
                offset = OWNER_W'(j - 1);
            end
        end
        ownerSum = {1'b0, pointer} + {1'b0, offset};
        if (ownerSum >= (OWNER_W + 1)'(NUM_REQ)) begin
            ownerPick = OWNER_W'(ownerSum - (OWNER_W + 1)'(NUM_REQ));
        end else begin
            ownerPick = OWNER_W'(ownerSum);
        end
    end

    // Saturating increment: counter never wraps back to zero.
    assign counterInc = (counter == '1) ? counter : counter + 8'd1;

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        pointerNext = pointer;
        ownerNext   = currentOwner;
        grantedNext = '0;
        endOutNext  = 1'b0;
        errOutNext  = 1'b0;

        unique case (state)
            IDLE: begin
                if (|request) begin
                    ownerNext              = ownerPick;
                    grantedNext[ownerPick] = 1'b1;
                    counterNext            = '0;
                    stateNext              = WAIT_BEGIN;
                end
            end
            WAIT_BEGIN: begin
                counterNext = counterInc;
                if (begin_transactionIN && end_transactionIN) begin
                    stateNext = RELEASE;
                end else if (begin_transactionIN) begin
                    counterNext = '0;
                    stateNext   = BUSY;
                end else if (counterInc >= 8'(START_TIMEOUT)) begin
                    // Owner never started: give up quietly, no bus error.
                    stateNext = RELEASE;
                end
            end
            BUSY: begin
                counterNext = counterInc;
                if (end_transactionIN || errorIN) begin
                    stateNext = RELEASE;
                end else if (counterInc >= 8'(BUSY_TIMEOUT)) begin
                    endOutNext = 1'b1;
                    errOutNext = 1'b1;
                    stateNext  = RELEASE;
                end
            end
            RELEASE: begin
                if (currentOwner == OWNER_W'(NUM_REQ - 1)) begin
                    pointerNext = '0;
                end else begin
                    pointerNext = currentOwner + 1'b1;
                end
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        ownerValidNext = (stateNext == WAIT_BEGIN) || (stateNext == BUSY);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            counter            <= '0;
            pointer            <= '0;
            currentOwner       <= '0;
            granted            <= '0;
            ownerValid         <= 1'b0;
            end_transactionOUT <= 1'b0;
            errorOUT           <= 1'b0;
        end else begin
            state              <= stateNext;
            counter            <= counterNext;
            pointer            <= pointerNext;
            currentOwner       <= ownerNext;
            granted            <= grantedNext;
            ownerValid         <= ownerValidNext;
            end_transactionOUT <= endOutNext;
            errorOUT           <= errOutNext;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Self-checking bench for bus_arbiter_rr: a fixed vector table, directed
//   multi-cycle sequences and a randomized run, all compared each cycle with a
//   transaction-level reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

    localparam int NREQ = 4;
    localparam int STO  = 8;
    localparam int BTO  = 12;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] granted;
    logic       begin_transactionIN;
    logic       end_transactionIN;
    logic       errorIN;
    logic       end_transactionOUT;
    logic       errorOUT;
    logic       ownerValid;
    logic [1:0] currentOwner;

    bus_arbiter_rr #(
        .NUM_REQ      (NREQ),
        .START_TIMEOUT(STO),
        .BUSY_TIMEOUT (BTO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .request            (request),
        .granted            (granted),
        .begin_transactionIN(begin_transactionIN),
        .end_transactionIN  (end_transactionIN),
        .errorIN            (errorIN),
        .end_transactionOUT (end_transactionOUT),
        .errorOUT           (errorOUT),
        .ownerValid         (ownerValid),
        .currentOwner       (currentOwner)
    );

    always #5 clock = ~clock;

    int nVec = 0;
    int nBad = 0;

    // Reference model: who owns the bus, how long they have held it, and how
    // many dead cycles remain before the next arbitration may happen.
    bit         mOwned;     // a master holds the bus
    bit         mStarted;   // its transaction has begun
    int         mOwner;
    int         mPtr;
    int         mAge;
    int         mGap;
    logic [3:0] mGrant;
    logic       mEnd;
    logic       mErr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] outs();
        return {granted, ownerValid, currentOwner, end_transactionOUT, errorOUT};
    endfunction

    function automatic logic [8:0] modelOuts();
        logic [31:0] o;
        o = mOwner;
        return {mGrant, mOwned ? 1'b1 : 1'b0, o[1:0], mEnd, mErr};
    endfunction

    task automatic modelRelease();
        mOwned   = 0;
        mStarted = 0;
        mGap     = 1;
        mPtr     = (mOwner + 1) % NREQ;
    endtask

    task automatic modelStep(input logic r, input logic [3:0] q, input logic b,
                             input logic e, input logic er);
        bit found;
        mGrant = '0;
        mEnd   = 1'b0;
        mErr   = 1'b0;
        if (r) begin
            mOwned = 0; mStarted = 0; mOwner = 0; mPtr = 0; mAge = 0; mGap = 0;
        end else if (!mOwned) begin
            if (mGap > 0) begin
                mGap--;
            end else if (q != 0) begin
                found = 0;
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && q[(mPtr + i) % NREQ]) begin
                        found  = 1;
                        mOwner = (mPtr + i) % NREQ;
                    end
                end
                mGrant[mOwner] = 1'b1;
                mOwned = 1;
                mAge   = 0;
            end
        end else if (!mStarted) begin
            mAge++;
            if (b && e)             modelRelease();
            else if (b) begin mStarted = 1; mAge = 0; end
            else if (mAge >= STO)   modelRelease();
        end else begin
            mAge++;
            if (e || er) modelRelease();
            else if (mAge >= BTO) begin
                mEnd = 1'b1;
                mErr = 1'b1;
                modelRelease();
            end
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic cyc(input logic r, input logic [3:0] q, input logic b,
                       input logic e, input logic er);
        reset = r; request = q;
        begin_transactionIN = b; end_transactionIN = e; errorIN = er;
        @(posedge clock);
        modelStep(r, q, b, e, er);
        #1;
        check("model", 32'(outs()), 32'(modelOuts()));
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic       b, e, er;
        logic [3:0] g;
        logic       ov;
        logic [1:0] own;
        logic       eo, erO;
    } vecT;

    vecT tbl[20];

    initial begin
        int order[5];
        int waited;
        int ovCount;
        bit found;
        bit abortSeen;
        logic [3:0] rq;
        logic rr;

        reset = 1'b1; request = '0;
        begin_transactionIN = 1'b0; end_transactionIN = 1'b0; errorIN = 1'b0;
        order = '{0, 1, 2, 3, 0};

        //          r     q      b     e     er   | g      ov    own    eo    erO
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 4'h4, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 4'h8, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].r, tbl[i].q, tbl[i].b, tbl[i].e, tbl[i].er);
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tbl[i].g, tbl[i].ov, tbl[i].own, tbl[i].eo, tbl[i].erO}));
        end

        // All four requesting, each owner does a begin then an end.
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            found  = 0;
            waited = 0;
            while (!found && waited < 10) begin
                cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
                waited++;
                if (granted != 4'h0) found = 1;
            end
            check($sformatf("rrOrder%0d", g), 32'(granted), 32'(1 << order[g]));
            if (g > 0) check($sformatf("rrSpacing%0d", g), 32'(waited), 32'd2);
            cyc(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
        end

        // Owner 1 never begins: silent abandon, pointer still advances.
        cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
        ovCount   = ownerValid ? 1 : 0;
        abortSeen = 0;
        found     = 0;
        for (int t = 0; t < 50 && !found; t++) begin
            cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
            if (errorOUT || end_transactionOUT) abortSeen = 1;
            if (ownerValid) ovCount++;
            else found = 1;
        end
        check("startTimeoutLen", 32'(ovCount), 32'(STO));
        check("startTimeoutSilent", 32'(abortSeen), 32'd0);
        cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("afterAbandon", 32'(granted), 32'h4);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Busy watchdog abort, then end arriving exactly on the timeout cycle.
        cyc(1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < BTO - 1; t++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("busyBeforeAbort", 32'(ownerValid), 32'd1);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("abortPulse", 32'({end_transactionOUT, errorOUT, ownerValid}), 32'b110);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("abortOneCycle", 32'({end_transactionOUT, errorOUT}), 32'b00);
        cyc(1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < BTO - 1; t++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("endWinsTimeout", 32'({end_transactionOUT, errorOUT, ownerValid}), 32'b000);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

        // Slave error mid-transfer releases the bus and moves the pointer on.
        cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("grantOwner1", 32'(granted), 32'h2);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("errorRelease", 32'({ownerValid, end_transactionOUT, errorOUT}), 32'b000);
        cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        check("afterError", 32'(granted), 32'h4);

        // Reset in the middle of a transfer.
        cyc(1'b0, 4'h4, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
        check("resetMidBusy", 32'(outs()), 32'd0);
        cyc(1'b0, 4'h4, 1'b0, 1'b0, 1'b0);
        check("regrantAfterReset", 32'({granted, currentOwner}), 32'({4'h4, 2'd2}));

        // Randomized traffic against the model.
        rq = 4'h0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 299) == 0);
            cyc(rr, rq, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
